// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns the fetch PC, issues sequential requests to a
// synchronous-read instruction memory and buffers returned words for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          pop;
    logic          push;
    logic          issue;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // A pop this cycle frees a slot, so a full buffer may still issue (pop credit).
    assign occupancy   = count + CW'(inflight);
    assign instr_valid = (count != '0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign push        = inflight & ~redirect_valid;
    assign issue       = ~rst & ~redirect_valid & ((occupancy < DEPTH_C) | pop);

    assign imem_req    = issue;
    assign imem_addr   = fetch_pc;
    assign instr_data  = fifo_word[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Redirect drops both buffered and in-flight work; low address bits are forced to word alignment.
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_word[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_word[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch initiator for the rv32i core: drives byte addresses into the instruction memory, captures returned words, and buffers them for decode behind a valid/ready handshake. It owns the fetch PC, advances it sequentially by 4, and redirects on taken branches/jumps, discarding any stale in-flight or buffered instructions. It sits between `instr_mem` (synchronous-read responder) and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset (must be 4-aligned)
- DEPTH, 2, instruction buffer entries (≥2)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_addr  out  32  byte address presented to instruction memory
- imem_req  out  1  fetch issued this cycle at imem_addr
- imem_rdata  in  32  instruction word, valid the cycle after the request
- instr_valid  out  1  buffer head holds a valid instruction
- instr_ready  in  1  decode accepts head this cycle
- instr_data  out  32  head instruction word
- instr_pc  out  32  PC of head instruction
- redirect_valid  in  1  control-flow change this cycle
- redirect_pc  in  32  new fetch target

## Operation
- State: fetch_pc (32), inflight (1), inflight_pc (32), FIFO of DEPTH × {pc, word}, count (0..DEPTH).
- Invariant: count + inflight ≤ DEPTH at every edge.
- imem_addr = fetch_pc (combinational). pop = instr_valid & instr_ready.
- Issue rule: imem_req = !rst & !redirect_valid & ((count + inflight < DEPTH) | pop).
- On issue: fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0); inflight <= 1, inflight_pc <= fetch_pc. No issue: inflight <= 0.
- Capture: if inflight and no redirect this cycle, push {inflight_pc, imem_rdata} at end of cycle.
- Push and pop in the same cycle: both happen, count unchanged; a pop from a full FIFO with a push is legal.
- instr_valid = (count != 0) & !redirect_valid; instr_data/instr_pc = head entry.
- Redirect (redirect_valid=1): FIFO flushed (count <= 0), in-flight response dropped (inflight <= 0, current imem_rdata not pushed), no issue this cycle, fetch_pc <= {redirect_pc[31:2], 2'b00}. instr_ready ignored that cycle (no pop). Misaligned redirect bits [1:0] silently cleared.
- Back-to-back redirects: last one wins; each flushes.
- Reset (async, any time, including mid-fetch or mid-redirect): fetch_pc = RESET_PC, inflight = 0, count = 0, FIFO pointers 0.

## Timing
- Reset values: imem_addr = RESET_PC, imem_req = 0, instr_valid = 0, instr_data = 0, instr_pc = 0 (FIFO storage cleared on reset; otherwise head fields are don't-care while instr_valid=0).
- Request in cycle N → imem_rdata sampled end of N+1 → instr_valid in N+2. Fetch-to-decode latency 2 cycles.
- First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC; first instr_valid two cycles later.
- Steady state with instr_ready held 1: one instruction per cycle, consecutive PCs.
- instr_ready low: fetch stops once count + inflight = DEPTH; resumes the same cycle ready returns (pop credit).
- Redirect in cycle R: imem_req=0 in R; redirect target issued in R+1; its instr_valid in R+3. No pre-redirect instruction ever appears at instr_valid after cycle R.
- instr_data/instr_pc stable while instr_valid=1 and instr_ready=0.

## Test plan
- Reset/stream: RESET_PC=0, memory word = address, instr_ready=1 → instr_valid from cycle 2, instr_pc 0,4,8,12… one per cycle, instr_data equals instr_pc.
- Backpressure: instr_ready=0 from cycle 2 for 5 cycles → exactly 2 entries buffered (PC 0,4), imem_req low while full, head stays PC 0; ready=1 → PCs 0,4,8 delivered with no gap or duplicate.
- Redirect: stream running, redirect_valid=1 with redirect_pc=0x40 in cycle 6 → instr_valid=0 in 6, imem_addr=0x40 with imem_req=1 in 7, instr_pc=0x40 valid in 9, then 0x44; no PC from old stream after cycle 5.
- Redirect while stalled and full: count=2, ready=0, redirect to 0x100 → FIFO empties, first valid PC is 0x100; misaligned target 0x103 → fetch at 0x100.
- Wrap: RESET_PC=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0, 4.
- Async reset mid-operation: assert rst between edges while inflight=1, count=1 → instr_valid=0 and imem_addr=RESET_PC immediately; after release, stream restarts from RESET_PC with no stale instruction.
